// File: rtl/neuron_feed_loader_pkg.sv
// Value types shared between the feed loader and the single-neuron evaluator.
package neuron_feed_loader_pkg;

  // Unsigned fraction in [0,1): neuron input value.
  typedef logic [7:0] zero2one_t;
  localparam zero2one_t zero2one_min = 8'h00;

  // Signed fraction: synaptic weight.
  typedef logic signed [15:0] frac_t;

endpackage

// File: rtl/neuron_feed_loader.sv
// Ping-pong loader: assembles a serial (input, weight) stream into N-wide
// vectors and holds each completed vector on the neuron's parallel ports.
module neuron_feed_loader
  import neuron_feed_loader_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  zero2one_t            in_data,
  input  frac_t                in_weight,
  input  logic                 in_last,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  output zero2one_t [N-1:0]    vec_in,
  output frac_t     [N-1:0]    vec_weights,
  output logic      [CW-1:0]   vec_count
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_e;

  zero2one_t   data_q   [2][N];
  frac_t       weight_q [2][N];
  logic [CW-1:0] count_q [2];
  bank_state_e state_q  [2];
  logic        fill_ptr;
  logic        pres_ptr;
  logic [CW-1:0] wr_idx;

  logic accept;
  logic close;
  logic release_vec;

  // Handshake decode: everything here depends on registered bank state only.
  always_comb begin
    in_ready    = (state_q[fill_ptr] == EMPTY);
    vec_valid   = (state_q[pres_ptr] == FULL);
    accept      = in_valid && in_ready;
    close       = accept && (in_last || (wr_idx == CW'(N - 1)));
    release_vec = vec_valid && vec_ready;
  end

  // Slot storage: contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q[fill_ptr][wr_idx[IW-1:0]]   <= in_data;
      weight_q[fill_ptr][wr_idx[IW-1:0]] <= in_weight;
    end
  end

  // Bank bookkeeping. Close and release always target different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      count_q[0] <= '0;
      count_q[1] <= '0;
      fill_ptr   <= 1'b0;
      pres_ptr   <= 1'b0;
      wr_idx     <= '0;
    end else begin
      if (accept) begin
        if (close) begin
          count_q[fill_ptr] <= wr_idx + CW'(1);
          state_q[fill_ptr] <= FULL;
          fill_ptr          <= ~fill_ptr;
          wr_idx            <= '0;
        end else begin
          wr_idx <= wr_idx + CW'(1);
        end
      end
      if (release_vec) begin
        state_q[pres_ptr] <= EMPTY;
        pres_ptr          <= ~pres_ptr;
      end
    end
  end

  // Presentation: unused slots read as neutral values so they add nothing.
  always_comb begin
    vec_count = vec_valid ? count_q[pres_ptr] : '0;
    for (int i = 0; i < int'(N); i++) begin
      vec_in[i]      = zero2one_min;
      vec_weights[i] = '0;
      if (vec_valid && (CW'(i) < count_q[pres_ptr])) begin
        vec_in[i]      = data_q[pres_ptr][i];
        vec_weights[i] = weight_q[pres_ptr][i];
      end
    end
  end

endmodule

// File: tb/tb_neuron_feed_loader.sv
// Directed bench for neuron_feed_loader with hand-computed expectations.
module tb_neuron_feed_loader;
  import neuron_feed_loader_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned CW = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  zero2one_t         in_data;
  frac_t             in_weight;
  logic              in_last;
  logic              vec_valid;
  logic              vec_ready;
  zero2one_t [N-1:0] vec_in;
  frac_t     [N-1:0] vec_weights;
  logic [CW-1:0]     vec_count;

  int n_cmp = 0;
  int n_err = 0;

  neuron_feed_loader #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_weight   (in_weight),
    .in_last     (in_last),
    .vec_valid   (vec_valid),
    .vec_ready   (vec_ready),
    .vec_in      (vec_in),
    .vec_weights (vec_weights),
    .vec_count   (vec_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1ns after the edge so outputs have settled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [15:0] w, input logic l);
    in_valid  = v;
    in_data   = d;
    in_weight = w;
    in_last   = l;
  endtask

  task automatic release_one();
    vec_ready = 1'b1;
    cyc();
    vec_ready = 1'b0;
  endtask

  initial begin
    int  acc;
    logic rdy;

    rst_n     = 1'b0;
    vec_ready = 1'b0;
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #12;
    check("rst_vec_valid", 32'(vec_valid), 32'd0);
    check("rst_vec_count", 32'(vec_count), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_vec_in0",   32'(vec_in[0]), 32'(zero2one_min));
    check("rst_vec_w0",    32'(vec_weights[0]), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Full 16-beat vector, data=i weight=i+1.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 16'(i + 1), i == 15);
      check("t1_in_ready", 32'(in_ready), 32'd1);
      if (i == 15) check("t1_valid_before_close", 32'(vec_valid), 32'd0);
      cyc();
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    check("t1_vec_valid",  32'(vec_valid), 32'd1);
    check("t1_vec_count",  32'(vec_count), 32'd16);
    check("t1_vec_in5",    32'(vec_in[5]), 32'd5);
    check("t1_vec_w5",     32'(vec_weights[5]), 32'd6);
    check("t1_vec_in15",   32'(vec_in[15]), 32'd15);
    check("t1_in_ready_after", 32'(in_ready), 32'd1);
    release_one();
    check("t1_released_valid", 32'(vec_valid), 32'd0);
    check("t1_released_count", 32'(vec_count), 32'd0);

    // Backpressure: consumer idle while 40 beats are offered.
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 8'(8'h40 + acc), 16'(16'h0200 + acc), (acc == 15) || (acc == 31));
      rdy = in_ready;
      if (c == 32) check("t3_stalled", 32'(in_ready), 32'd0);
      if (c >= 32) begin
        check("t3_hold_in3",  32'(vec_in[3]), 32'h43);
        check("t3_hold_w15",  32'(vec_weights[15]), 32'h020F);
        check("t3_hold_cnt",  32'(vec_count), 32'd16);
      end
      cyc();
      if (rdy) acc++;
    end
    check("t3_accepted", 32'(acc), 32'd32);
    vec_ready = 1'b1;
    cyc();
    vec_ready = 1'b0;
    check("t3_ready_after_release", 32'(in_ready), 32'd1);
    check("t3_second_in0", 32'(vec_in[0]), 32'h50);
    check("t3_second_w0",  32'(vec_weights[0]), 32'h0210);
    check("t3_second_cnt", 32'(vec_count), 32'd16);
    for (int b = 32; b < 40; b++) begin
      drive(1'b1, 8'(8'h40 + b), 16'(16'h0200 + b), b == 39);
      check("t3_tail_ready", 32'(in_ready), 32'd1);
      cyc();
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    check("t3_order_kept", 32'(vec_in[0]), 32'h50);
    release_one();
    check("t3_third_cnt",  32'(vec_count), 32'd8);
    check("t3_third_in7",  32'(vec_in[7]), 32'h67);
    check("t3_third_in8",  32'(vec_in[8]), 32'(zero2one_min));
    check("t3_third_w8",   32'(vec_weights[8]), 32'd0);
    release_one();
    check("t3_drained", 32'(vec_valid), 32'd0);

    // Short vector over a bank holding stale data.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 16'(16'h0100 + i), i == 2);
      cyc();
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    check("t2_valid",  32'(vec_valid), 32'd1);
    check("t2_count",  32'(vec_count), 32'd3);
    check("t2_in2",    32'(vec_in[2]), 32'hA2);
    check("t2_w2",     32'(vec_weights[2]), 32'h0102);
    check("t2_in3",    32'(vec_in[3]), 32'(zero2one_min));
    check("t2_w3",     32'(vec_weights[3]), 32'd0);
    check("t2_in15",   32'(vec_in[15]), 32'(zero2one_min));
    check("t2_w15",    32'(vec_weights[15]), 32'd0);
    release_one();

    // 20 beats without in_last: auto-close at 16, 4 carried into next bank.
    for (int b = 0; b < 20; b++) begin
      drive(1'b1, 8'(8'h80 + b), 16'(16'h0300 + b), 1'b0);
      check("t4_ready", 32'(in_ready), 32'd1);
      if (b == 15) check("t4_not_yet_valid", 32'(vec_valid), 32'd0);
      cyc();
      if (b == 15) begin
        check("t4_auto_valid", 32'(vec_valid), 32'd1);
        check("t4_auto_count", 32'(vec_count), 32'd16);
      end
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    check("t4_first_in0", 32'(vec_in[0]), 32'h80);
    release_one();
    check("t4_partial_not_valid", 32'(vec_valid), 32'd0);
    drive(1'b1, 8'h94, 16'h0314, 1'b1);
    cyc();
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    check("t4_tail_count", 32'(vec_count), 32'd5);
    check("t4_tail_in0",   32'(vec_in[0]), 32'h90);
    check("t4_tail_in4",   32'(vec_in[4]), 32'h94);
    release_one();

    // Close on one bank in the same cycle the other is released.
    drive(1'b1, 8'hC0, 16'h0400, 1'b0); cyc();
    drive(1'b1, 8'hC1, 16'h0401, 1'b1); cyc();
    drive(1'b1, 8'hD0, 16'h0500, 1'b0); cyc();
    drive(1'b1, 8'hD1, 16'h0501, 1'b0); cyc();
    check("t5_a_presented", 32'(vec_in[1]), 32'hC1);
    drive(1'b1, 8'hD2, 16'h0502, 1'b1);
    vec_ready = 1'b1;
    cyc();
    vec_ready = 1'b0;
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    check("t5_valid",    32'(vec_valid), 32'd1);
    check("t5_in0",      32'(vec_in[0]), 32'hD0);
    check("t5_count",    32'(vec_count), 32'd3);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    release_one();

    // Async reset with one vector presented and a partial fill in flight.
    for (int b = 0; b < 7; b++) begin
      drive(1'b1, 8'(8'hE0 + b), 16'(16'h0600 + b), b == 3);
      cyc();
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    check("t6_pre_valid", 32'(vec_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(vec_valid), 32'd0);
    check("t6_rst_ready", 32'(in_ready), 32'd1);
    check("t6_rst_count", 32'(vec_count), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t6_no_pulse", 32'(vec_valid), 32'd0);
    drive(1'b1, 8'hF0, 16'h0700, 1'b0); cyc();
    drive(1'b1, 8'hF1, 16'h0701, 1'b1); cyc();
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    check("t6_count", 32'(vec_count), 32'd2);
    check("t6_in1",   32'(vec_in[1]), 32'hF1);
    check("t6_in2",   32'(vec_in[2]), 32'(zero2one_min));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_feed_loader.md
Name: neuron_feed_loader

Overview:
- Upstream feeder for the combinational single-neuron evaluator.
- Accepts a serial valid/ready stream of (input, weight) pairs and assembles them into N-wide parallel vectors.
- Presents each completed vector, stable and held, to the neuron's `in[]`/`weights[]` ports.
- Ping-pong buffered: one bank fills while the other is presented, so a continuous input stream never stalls on a single consumer hold.

Parameters:
- N, 16, vector length; must match the neuron's N; N >= 2.
- CW, $clog2(N+1), width of element count fields.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream pair valid.
- in_ready  output  1  loader can accept a pair this cycle.
- in_data  input  zero2one_t  neuron input value.
- in_weight  input  frac_t  matching weight.
- in_last  input  1  marks the final pair of a vector; qualifies with in_valid.
- vec_valid  output  1  presented vector is complete.
- vec_ready  input  1  consumer takes the vector this cycle.
- vec_in  output  zero2one_t [N-1:0]  assembled inputs, index = arrival order.
- vec_weights  output  frac_t [N-1:0]  assembled weights.
- vec_count  output  CW  number of real entries in presented vector (1..N).

Behaviour:
- Storage: two banks (0/1), each with N data slots, N weight slots, a CW-bit count, and a 2-state flag EMPTY/FULL.
- Pointers: fill_ptr (bank being written), pres_ptr (bank presented). Fill position register wr_idx (CW bits).
- Reset (async, rst_n=0): both banks EMPTY, counts 0, fill_ptr=pres_ptr=0, wr_idx=0. Slot contents need no reset.
- Reset outputs: vec_valid=0, vec_count=0, vec_in all `zero2one_min`, vec_weights all 0, in_ready=1 (combinational from bank state).
- in_ready = (bank[fill_ptr] == EMPTY). It is combinational from registers only, never from in_valid.
- Accept when in_valid && in_ready:
  - Write in_data/in_weight into bank[fill_ptr] slot wr_idx; wr_idx++.
- Close condition: accepted beat with in_last=1, or accepted beat where wr_idx == N-1.
  - On close, bank[fill_ptr] count = wr_idx+1 and the bank becomes FULL.
  - On close, fill_ptr toggles and wr_idx=0.
  - After N beats without in_last, the vector closes anyway and the next beat starts a new vector; no error is raised.
- vec_valid = (bank[pres_ptr] == FULL).
- Latency: vec_valid rises the cycle after the closing beat is accepted.
- Presentation while vec_valid=1:
  - vec_in[i]/vec_weights[i] = stored slot when i < count.
  - Otherwise vec_in[i] = `zero2one_min` and vec_weights[i] = 0, so unused slots contribute nothing to the sum.
  - vec_count = count.
- When vec_valid=0: all outputs are at their reset values.
- Release on vec_valid && vec_ready: bank[pres_ptr] becomes EMPTY and pres_ptr toggles.
- Hold: while vec_valid && !vec_ready, the outputs do not change in any bit.
- Simultaneous close and release in the same cycle: both take effect.
  - Banks differ by construction, so there is no conflict.
  - A bank released this cycle may be refilled starting next cycle, because in_ready is registered-state based.
- Both banks FULL: in_ready=0; upstream stalls, and wr_idx stays 0.
- Reset mid-vector: any partial fill and any presented vector are discarded with no output pulse.
- Throughput: one pair per cycle sustained if the consumer accepts each vector within N cycles of presentation.
- No arithmetic on values; data is passed bit-exact.

Test Plan:
- Reset, then 16 pairs back-to-back with in_data=i, in_weight=i+1, in_last only on beat 15:
  - vec_valid rises the cycle after beat 15.
  - vec_count=16, vec_in[5]=5, vec_weights[5]=6.
  - in_ready stays 1 throughout.
- Short vector: 3 pairs with in_last on the 3rd:
  - vec_count=3.
  - vec_in[3..15]=`zero2one_min` and vec_weights[3..15]=0.
- Backpressure: vec_ready=0, stream 40 pairs with in_last every 16th:
  - After two vectors are closed (32 beats), in_ready=0 and beats 33..40 stall.
  - Presented outputs are unchanged each cycle.
  - Raising vec_ready for 1 cycle gives in_ready=1 on the next cycle and bank order is preserved.
- No in_last over 20 beats:
  - First vector closes at beat 16 with count=16.
  - Beats 17..20 fill the next bank with wr_idx=4 and no vec_valid for it.
- Same-cycle close and release:
  - Consumer asserts vec_ready in exactly the cycle the other bank's last beat is accepted.
  - Next cycle: vec_valid=1 with the new vector, and in_ready=1.
- Assert rst_n=0 after 7 beats with one vector presented:
  - vec_valid=0 and in_ready=1 immediately, asynchronously.
  - After release, a fresh 2-beat vector reports count=2.
